ex_mdu_seq: RTL and testbench
=============================

Name: ex_mdu_seq

Overview:
- Iterative RV32M multiply/divide sequencer in the EX stage, next to the main ALU.
- Accepts post-forwarding operands for M-extension instructions (funct7 = 0000001) and runs a shared shift-add / restoring-divide datapath for XLEN iterations.
- Stalls IF/ID/EX and holds the registered result until writeback can take it.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- ex_mdu_req  in  1  valid M-extension instruction present in EX.
- ex_mdu_func3  in  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- ex_flush  in  1  branch/jump flush of EX.
- op_a  in  XLEN  forwarded rs1 value.
- op_b  in  XLEN  forwarded rs2 value.
- mdu_stall  out  1  hold PC, IF/ID and ID/EX.
- mdu_busy  out  1  state is CALC.
- mdu_done  out  1  one-cycle pulse; mdu_result is valid.
- mdu_result  out  XLEN  registered result.

Behaviour:
- Reset (async, rstn=0):
  - state=IDLE, counter=0, mdu_result=0, mdu_done=0, mdu_busy=0.
  - mdu_stall is forced to 0 while rstn=0.
- States: IDLE, CALC, DONE.
- IDLE:
  - start = ex_mdu_req & ~ex_flush.
  - On start, latch |op_a|, |op_b| (sign-stripped per op), the result-sign flag and func3; go to CALC; counter=0.
  - mdu_stall = start (combinational, same cycle).
- CALC:
  - One iteration per cycle; mdu_stall=1, mdu_busy=1.
  - After iteration XLEN-1, apply the sign fix and register mdu_result; go to DONE.
- DONE:
  - mdu_stall=0, mdu_done=1; pipeline advances this cycle.
  - Next state is IDLE unconditionally. ex_mdu_req is not sampled in DONE, which prevents a restart on the same instruction.
- Latency: start at cycle T, CALC T+1..T+XLEN, DONE at T+XLEN+1 (33 for XLEN=32). mdu_stall is high for XLEN+1 cycles.
- Signedness rules:
  - MULH: both operands signed. MULHSU: op_a signed, op_b unsigned. MULHU, DIVU, REMU: unsigned.
  - MUL returns product[XLEN-1:0]; the MULH variants return product[2XLEN-1:XLEN].
  - Quotient sign = sign(a) ^ sign(b). Remainder sign = sign(a).
- Divide by zero: quotient = all ones, remainder = op_a (both signed and unsigned).
- Signed overflow (0x80000000 / -1): quotient = 0x80000000, remainder = 0.
- ex_flush:
  - In CALC or DONE: next state IDLE, mdu_done stays 0, mdu_result keeps its prior value, mdu_stall drops the same cycle.
  - In IDLE: suppresses start.
- Back-to-back M instructions: the second one starts in the IDLE cycle after DONE (one bubble-free handoff).
- mdu_result changes only on entry to DONE or on reset.

Optional Feature:
- Macro: MDU_EARLY_OUT_EN.
- Defined: divide-by-zero, signed overflow, and any multiply with an operand equal to 0 skip CALC. The result is registered in the start cycle and DONE occurs at T+1; mdu_stall is high for 1 cycle.
- Undefined: every op takes the full XLEN+1 cycles. The special-case results are still exactly as specified, produced at the end of CALC.

Decomposition:
- define.vh additions:
  - func3 encodings: MDU_MUL … MDU_REMU.
  - state encodings: MDU_IDLE, MDU_CALC, MDU_DONE.
  - the M-extension funct7 constant.
- Sub-module mdu_core: one-iteration combinational step (shift-add multiply / restoring subtract) plus sign-fix logic. ex_mdu_seq holds the FSM, counter and registers.

Test Plan:
1. MUL 7 × 0xFFFFFFFD (-3) → mdu_result 0xFFFFFFEB; mdu_stall high cycles T..T+32; mdu_done pulse at T+33.
2. MULH 0x80000000×0x80000000 → 0x40000000; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
3. DIV 0xFFFFFFF9 (-7)/2 → 0xFFFFFFFD; REM → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
4. DIV 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. Done at T+1 with MDU_EARLY_OUT_EN, T+33 without.
5. Flush and back-to-back:
   - MUL started at T, ex_flush at T+10 → IDLE at T+11, mdu_stall 0 at T+10, no mdu_done, result unchanged.
   - MUL then DIV back-to-back → DIV start cycle = MUL DONE cycle + 1.
6. rstn low at T+5 mid-CALC → mdu_stall 0 immediately, mdu_result 0. After release, ex_mdu_req=0 keeps IDLE.

Source files
------------

// File: rtl/ex_mdu_seq_pkg.sv
// Shared types and helpers for the iterative RV32M multiply/divide sequencer.
package ex_mdu_seq_pkg;

  localparam logic [6:0] FUNCT7_M = 7'b0000001;

  typedef enum logic [2:0] {
    MDU_MUL    = 3'b000,
    MDU_MULH   = 3'b001,
    MDU_MULHSU = 3'b010,
    MDU_MULHU  = 3'b011,
    MDU_DIV    = 3'b100,
    MDU_DIVU   = 3'b101,
    MDU_REM    = 3'b110,
    MDU_REMU   = 3'b111
  } mdu_func_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_CALC = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // Operation context latched at start and held through CALC.
  typedef struct packed {
    mdu_func_e func;
    logic      neg;
  } mdu_op_t;

  function automatic logic a_signed(input mdu_func_e f);
    return f inside {MDU_MULH, MDU_MULHSU, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic b_signed(input mdu_func_e f);
    return f inside {MDU_MULH, MDU_DIV, MDU_REM};
  endfunction

  function automatic logic is_div(input mdu_func_e f);
    return f inside {MDU_DIV, MDU_DIVU, MDU_REM, MDU_REMU};
  endfunction

  function automatic logic is_rem(input mdu_func_e f);
    return f inside {MDU_REM, MDU_REMU};
  endfunction

endpackage

// File: rtl/ex_mdu_seq_core.sv
// One combinational iteration of shift-add multiply / restoring divide on
// unsigned magnitudes, plus the sign fix applied to the post-iteration value.
module ex_mdu_seq_core
  import ex_mdu_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  mdu_func_e       func,
  input  logic            neg,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] mag_b,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt,
  output logic [XLEN-1:0] result
);

  logic [XLEN:0]     sum;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     trial;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] prod_fix;

  // hi = partial product / remainder, lo = multiplier / dividend-quotient
  always_comb begin : step
    hi_nxt  = hi;
    lo_nxt  = lo;
    sum     = '0;
    shifted = '0;
    trial   = '0;
    if (is_div(func)) begin
      shifted = {hi, lo[XLEN-1]};
      trial   = shifted - {1'b0, mag_b};
      if (trial[XLEN]) begin
        hi_nxt = shifted[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end else begin
        hi_nxt = trial[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end
    end else begin
      sum              = {1'b0, hi} + (lo[0] ? {1'b0, mag_b} : '0);
      {hi_nxt, lo_nxt} = {sum, lo[XLEN-1:1]};
    end
  end

  always_comb begin : sign_fix
    prod     = {hi_nxt, lo_nxt};
    prod_fix = neg ? -prod : prod;
    result   = '0;
    case (func)
      MDU_MUL:                         result = prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: result = prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               result = neg ? -lo_nxt : lo_nxt;
      default:                         result = neg ? -hi_nxt : hi_nxt;
    endcase
  end

endmodule

// File: rtl/ex_mdu_seq.sv
// EX-stage RV32M sequencer: FSM, iteration counter and operand/result registers.
// Optional MDU_EARLY_OUT_EN finishes trivial multiplies and special divides in one cycle.
module ex_mdu_seq
  import ex_mdu_seq_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ex_mdu_req,
  input  logic [2:0]      ex_mdu_func3,
  input  logic            ex_flush,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            mdu_stall,
  output logic            mdu_busy,
  output logic            mdu_done,
  output logic [XLEN-1:0] mdu_result
);

  mdu_state_e       state, state_nxt;
  mdu_op_t          op;
  mdu_func_e        func_in;
  logic [CNT_W-1:0] cnt;
  logic [XLEN-1:0]  hi, lo, mag_b;
  logic [XLEN-1:0]  hi_nxt, lo_nxt, core_result;
  logic [XLEN-1:0]  a_mag, b_mag, early_res;
  logic             a_neg, b_neg, neg_in;
  logic             start, stall_c, last, early_hit;

  assign func_in = mdu_func_e'(ex_mdu_func3);
  assign a_neg   = a_signed(func_in) & op_a[XLEN-1];
  assign b_neg   = b_signed(func_in) & op_b[XLEN-1];
  assign a_mag   = a_neg ? -op_a : op_a;
  assign b_mag   = b_neg ? -op_b : op_b;
  assign last    = (cnt == CNT_W'(XLEN - 1));

  // Divide by zero keeps an unnegated all-ones quotient; remainder follows the dividend.
  always_comb begin : sign_sel
    neg_in = a_neg ^ b_neg;
    if (is_rem(func_in)) begin
      neg_in = a_neg;
    end else if (is_div(func_in)) begin
      neg_in = (a_neg ^ b_neg) & (|op_b);
    end
  end

`ifdef MDU_EARLY_OUT_EN
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  always_comb begin : early_out
    early_hit = 1'b0;
    early_res = '0;
    if (!is_div(func_in)) begin
      early_hit = (op_a == '0) || (op_b == '0);
    end else if (op_b == '0) begin
      early_hit = 1'b1;
      early_res = is_rem(func_in) ? op_a : '1;
    end else if (b_signed(func_in) && (op_a == SMIN) && (op_b == '1)) begin
      early_hit = 1'b1;
      early_res = is_rem(func_in) ? '0 : SMIN;
    end
  end
`else
  assign early_hit = 1'b0;
  assign early_res = '0;
`endif

  ex_mdu_seq_core #(
    .XLEN (XLEN)
  ) u_mdu_core (
    .func   (op.func),
    .neg    (op.neg),
    .hi     (hi),
    .lo     (lo),
    .mag_b  (mag_b),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt),
    .result (core_result)
  );

  always_ff @(posedge clk or negedge rstn) begin : regs
    if (!rstn) begin
      state      <= MDU_IDLE;
      op         <= '0;
      cnt        <= '0;
      hi         <= '0;
      lo         <= '0;
      mag_b      <= '0;
      mdu_result <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        op    <= '{func: func_in, neg: neg_in};
        cnt   <= '0;
        hi    <= '0;
        lo    <= is_div(func_in) ? a_mag : b_mag;
        mag_b <= is_div(func_in) ? b_mag : a_mag;
        if (early_hit) begin
          mdu_result <= early_res;
        end
      end else if (state == MDU_CALC) begin
        cnt <= cnt + CNT_W'(1);
        hi  <= hi_nxt;
        lo  <= lo_nxt;
        if (last && !ex_flush) begin
          mdu_result <= core_result;
        end
      end
    end
  end

  // DONE never samples ex_mdu_req so a held instruction cannot restart.
  always_comb begin : fsm
    state_nxt = state;
    start     = 1'b0;
    stall_c   = 1'b0;
    mdu_busy  = 1'b0;
    mdu_done  = 1'b0;
    case (state)
      MDU_IDLE: begin
        start   = ex_mdu_req & ~ex_flush;
        stall_c = start;
        if (start) begin
          state_nxt = early_hit ? MDU_DONE : MDU_CALC;
        end
      end
      MDU_CALC: begin
        mdu_busy = 1'b1;
        stall_c  = ~ex_flush;
        if (ex_flush) begin
          state_nxt = MDU_IDLE;
        end else if (last) begin
          state_nxt = MDU_DONE;
        end
      end
      MDU_DONE: begin
        mdu_done  = ~ex_flush;
        state_nxt = MDU_IDLE;
      end
      default: state_nxt = MDU_IDLE;
    endcase
  end

  assign mdu_stall = stall_c & rstn;

endmodule

// File: tb/tb_ex_mdu_seq.sv
// Scoreboard bench for ex_mdu_seq: results, latency, stall/busy/done timing, flush and reset.
module tb_ex_mdu_seq;

  localparam logic [2:0] F_MUL = 3'd0, F_MULH = 3'd1, F_MULHSU = 3'd2, F_MULHU = 3'd3;
  localparam logic [2:0] F_DIV = 3'd4, F_DIVU = 3'd5, F_REM = 3'd6, F_REMU = 3'd7;

  logic        clk;
  logic        rstn;
  logic        ex_mdu_req;
  logic [2:0]  ex_mdu_func3;
  logic        ex_flush;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mdu_stall;
  logic        mdu_busy;
  logic        mdu_done;
  logic [31:0] mdu_result;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  logic [31:0] last_result = 32'h0;
  logic [31:0] exp_q[$];

  ex_mdu_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .ex_mdu_req   (ex_mdu_req),
    .ex_mdu_func3 (ex_mdu_func3),
    .ex_flush     (ex_flush),
    .op_a         (op_a),
    .op_b         (op_b),
    .mdu_stall    (mdu_stall),
    .mdu_busy     (mdu_busy),
    .mdu_done     (mdu_done),
    .mdu_result   (mdu_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_mdu(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [63:0] sa, sb, ub;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'h0, b};
    case (f)
      F_MUL:    begin p = {32'h0, a} * {32'h0, b}; return p[31:0]; end
      F_MULH:   begin p = sa * sb; return p[63:32]; end
      F_MULHSU: begin p = sa * ub; return p[63:32]; end
      F_MULHU:  begin p = {32'h0, a} * {32'h0, b}; return p[63:32]; end
      F_DIV: begin
        if (b == 32'h0) return 32'hffffffff;
        if (a == 32'h80000000 && b == 32'hffffffff) return 32'h80000000;
        return 32'($signed(a) / $signed(b));
      end
      F_REM: begin
        if (b == 32'h0) return a;
        if (a == 32'h80000000 && b == 32'hffffffff) return 32'h0;
        return 32'($signed(a) % $signed(b));
      end
      F_DIVU:   return (b == 32'h0) ? 32'hffffffff : a / b;
      default:  return (b == 32'h0) ? a : a % b;
    endcase
  endfunction

  function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MDU_EARLY_OUT_EN
    if (!f[2] && (a == 32'h0 || b == 32'h0)) return 1;
    if (f[2] && b == 32'h0) return 1;
    if ((f == F_DIV || f == F_REM) && a == 32'h80000000 && b == 32'hffffffff) return 1;
`endif
    return 33;
  endfunction

  task automatic start_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] expv);
    @(negedge clk);
    ex_mdu_req   = 1'b1;
    ex_mdu_func3 = f;
    op_a         = a;
    op_b         = b;
    ex_flush     = 1'b0;
    exp_q.push_back(expv);
    start_cyc = cyc;
    #1;
    checks++;
    if (mdu_stall !== 1'b1) begin
      errors++;
      $display("FAIL start_stall f=%0d got %b want 1", f, mdu_stall);
    end
  endtask

  task automatic wait_done(input string name, input int lat);
    int stalls, busy_n;
    bit seen;
    logic [31:0] expv;
    stalls = 1;
    busy_n = 0;
    seen   = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      #1;
      if (mdu_done === 1'b1) seen = 1'b1;
      else begin
        if (mdu_stall === 1'b1) stalls++;
        if (mdu_busy === 1'b1) busy_n++;
      end
    end
    ex_mdu_req = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout waiting for mdu_done", name);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      return;
    end
    done_cyc = cyc;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard empty at mdu_done", name);
      return;
    end
    expv = exp_q.pop_front();
    last_result = expv;
    checks++;
    if (mdu_result !== expv) begin
      errors++;
      $display("FAIL %s result got %h want %h", name, mdu_result, expv);
    end
    checks++;
    if (done_cyc - start_cyc != lat) begin
      errors++;
      $display("FAIL %s latency got %0d want %0d", name, done_cyc - start_cyc, lat);
    end
    checks++;
    if (stalls != lat) begin
      errors++;
      $display("FAIL %s stall_cycles got %0d want %0d", name, stalls, lat);
    end
    checks++;
    if (busy_n != lat - 1) begin
      errors++;
      $display("FAIL %s busy_cycles got %0d want %0d", name, busy_n, lat - 1);
    end
    checks++;
    if (mdu_stall !== 1'b0) begin
      errors++;
      $display("FAIL %s stall_at_done got %b want 0", name, mdu_stall);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] expv);
    start_op(f, a, b, expv);
    wait_done(name, exp_lat(f, a, b));
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    ex_mdu_req = 1'b1;
    ex_mdu_func3 = F_MUL;
    ex_flush = 1'b0;
    op_a = 32'd3;
    op_b = 32'd4;
    #12;
    checks++;
    if (mdu_stall !== 1'b0 || mdu_busy !== 1'b0 || mdu_done !== 1'b0 || mdu_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_state stall=%b busy=%b done=%b result=%h want 0/0/0/0",
               mdu_stall, mdu_busy, mdu_done, mdu_result);
    end
    ex_mdu_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (mdu_stall !== 1'b0 || mdu_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle stall=%b busy=%b want 0/0", mdu_stall, mdu_busy);
    end
  endtask

  task automatic test_mul();
    run_op("mul_7_m3", F_MUL, 32'd7, 32'hfffffffd, 32'hffffffeb);
  endtask

  task automatic test_mulh();
    run_op("mulh", F_MULH, 32'h80000000, 32'h80000000, 32'h40000000);
    run_op("mulhu", F_MULHU, 32'hffffffff, 32'hffffffff, 32'hfffffffe);
    run_op("mulhsu", F_MULHSU, 32'hffffffff, 32'hffffffff, 32'hffffffff);
  endtask

  task automatic test_div();
    run_op("div_m7_2", F_DIV, 32'hfffffff9, 32'd2, 32'hfffffffd);
    run_op("rem_m7_2", F_REM, 32'hfffffff9, 32'd2, 32'hffffffff);
    run_op("divu_100_7", F_DIVU, 32'd100, 32'd7, 32'd14);
    run_op("remu_100_7", F_REMU, 32'd100, 32'd7, 32'd2);
  endtask

  task automatic test_special();
    run_op("div_by_zero", F_DIV, 32'd5, 32'd0, 32'hffffffff);
    run_op("rem_by_zero", F_REM, 32'd5, 32'd0, 32'd5);
    run_op("divu_by_zero", F_DIVU, 32'hdeadbeef, 32'd0, 32'hffffffff);
    run_op("rem_neg_by_zero", F_REM, 32'hfffffff9, 32'd0, 32'hfffffff9);
    run_op("div_overflow", F_DIV, 32'h80000000, 32'hffffffff, 32'h80000000);
    run_op("rem_overflow", F_REM, 32'h80000000, 32'hffffffff, 32'h0);
    run_op("mul_zero", F_MULH, 32'h0, 32'h12345678, 32'h0);
  endtask

  task automatic test_back_to_back();
    int mul_done;
    run_op("b2b_mul", F_MUL, 32'd11, 32'd13, 32'd143);
    mul_done = done_cyc;
    run_op("b2b_div", F_DIV, 32'd143, 32'hfffffff5, 32'hfffffff3);
    checks++;
    if (start_cyc != mul_done + 1) begin
      errors++;
      $display("FAIL b2b_handoff start got %0d want %0d", start_cyc, mul_done + 1);
    end
  endtask

  task automatic test_flush();
    bit saw_done;
    start_op(F_MUL, 32'd3, 32'd5, 32'd15);
    repeat (10) @(negedge clk);
    #1;
    checks++;
    if (mdu_busy !== 1'b1 || mdu_stall !== 1'b1) begin
      errors++;
      $display("FAIL flush_pre busy=%b stall=%b want 1/1", mdu_busy, mdu_stall);
    end
    ex_flush = 1'b1;
    #1;
    checks++;
    if (mdu_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall got %b want 0", mdu_stall);
    end
    @(negedge clk);
    ex_flush = 1'b0;
    ex_mdu_req = 1'b0;
    #1;
    checks++;
    if (mdu_busy !== 1'b0 || mdu_stall !== 1'b0) begin
      errors++;
      $display("FAIL flush_idle busy=%b stall=%b want 0/0", mdu_busy, mdu_stall);
    end
    void'(exp_q.pop_front());
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      #1;
      if (mdu_done === 1'b1) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL flush_no_done got done pulse want none");
    end
    checks++;
    if (mdu_result !== last_result) begin
      errors++;
      $display("FAIL flush_result got %h want %h", mdu_result, last_result);
    end
  endtask

  task automatic test_random();
    logic [2:0] f;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      f = 3'($urandom_range(0, 7));
      a = $urandom();
      b = $urandom();
      if (i == 3) b = 32'h0;
      if (i == 6) begin a = 32'h80000000; b = 32'hffffffff; end
      if (i == 9) a = 32'h0;
      if (i == 10) b = 32'h00000003;
      run_op("random", f, a, b, ref_mdu(f, a, b));
    end
  endtask

  task automatic test_reset_mid();
    bit bad;
    start_op(F_MUL, 32'd9, 32'd9, 32'd81);
    repeat (5) @(negedge clk);
    rstn = 1'b0;
    #1;
    checks++;
    if (mdu_stall !== 1'b0 || mdu_busy !== 1'b0 || mdu_result !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid stall=%b busy=%b result=%h want 0/0/0",
               mdu_stall, mdu_busy, mdu_result);
    end
    void'(exp_q.pop_front());
    ex_mdu_req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    bad = 1'b0;
    repeat (5) begin
      @(negedge clk);
      #1;
      if (mdu_busy !== 1'b0 || mdu_stall !== 1'b0 || mdu_done !== 1'b0 || mdu_result !== 32'h0)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL reset_release_idle busy=%b stall=%b done=%b result=%h want idle",
               mdu_busy, mdu_stall, mdu_done, mdu_result);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_mulh();
    test_div();
    test_special();
    test_back_to_back();
    test_flush();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
